// File: rtl/dwc_dispatch.sv
// Initiator side of the duplicate-with-comparison channel: latches two replica
// results for the comparator, waits for its verdict and replays on mismatch or timeout.
module dwc_dispatch #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 2,
  localparam int unsigned CNT_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rep_a_valid,
  input  logic [DATA_W-1:0] rep_a_data,
  input  logic              rep_b_valid,
  input  logic [DATA_W-1:0] rep_b_data,
  input  logic              isMatch,
  input  logic              interupt_prompt,
  input  logic              fault_clr,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [1:0]        data_set,
  output logic              cmp_clear,
  output logic              replay_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              fault,
  output logic [CNT_W-1:0]  retry_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COLLECT, S_WAIT, S_RETRY, S_DONE, S_FAULT
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] retry_n;
  logic [1:0]       set_n;
  logic             lat_a, lat_b;
  logic             timed_out;

  assign timed_out = (timer == TMR_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state, timer, retry count and latch enables
  always_comb begin
    state_n = state;
    timer_n = timer;
    retry_n = retry_cnt;
    set_n   = data_set;
    lat_a   = 1'b0;
    lat_b   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CLEAR;
          retry_n = '0;
        end
      end
      S_CLEAR: begin
        timer_n = '0;
        state_n = S_COLLECT;
      end
      S_COLLECT: begin
        timer_n = TMR_W'(timer + 1'b1);
        lat_a   = rep_a_valid & ~data_set[0];
        lat_b   = rep_b_valid & ~data_set[1];
        set_n   = data_set | {lat_b, lat_a};
        if (timed_out)   state_n = S_RETRY;
        else if (&set_n) state_n = S_WAIT;
      end
      S_WAIT: begin
        timer_n = TMR_W'(timer + 1'b1);
        // A mismatch verdict outranks a simultaneous match
        if (interupt_prompt) state_n = S_RETRY;
        else if (isMatch)    state_n = S_DONE;
        else if (timed_out)  state_n = S_RETRY;
      end
      S_RETRY: begin
        if (retry_cnt == CNT_MAX) begin
          state_n = S_FAULT;
        end else begin
          retry_n = CNT_W'(retry_cnt + 1'b1);
          state_n = S_CLEAR;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_FAULT: begin
        if (fault_clr) begin
          state_n = S_IDLE;
          retry_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Comparator inputs read as empty for the whole CLEAR cycle
    if (state_n == S_CLEAR) begin
      set_n   = '0;
      timer_n = '0;
    end
  end

  // Timer and retry counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer     <= '0;
      retry_cnt <= '0;
    end else begin
      timer     <= timer_n;
      retry_cnt <= retry_n;
    end
  end

  // Replica capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_a   <= '0;
      data_b   <= '0;
      data_set <= '0;
    end else begin
      if (lat_a) data_a <= rep_a_data;
      if (lat_b) data_b <= rep_b_data;
      data_set <= set_n;
    end
  end

  // Outputs decoded from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_clear  <= 1'b0;
      replay_req <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      result     <= '0;
    end else begin
      cmp_clear  <= (state_n == S_CLEAR);
      replay_req <= (state_n == S_RETRY) && (retry_cnt != CNT_MAX);
      busy       <= (state_n != S_IDLE) && (state_n != S_FAULT);
      done       <= (state_n == S_DONE);
      fault      <= (state_n == S_FAULT);
      if (state_n == S_DONE) result <= data_a;
    end
  end

endmodule

// File: tb/tb_dwc_dispatch.sv
// Directed self-checking bench for dwc_dispatch with default parameters.
module tb_dwc_dispatch;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, rep_a_valid, rep_b_valid, isMatch, interupt_prompt, fault_clr;
  logic [DATA_W-1:0] rep_a_data, rep_b_data;
  logic [DATA_W-1:0] data_a, data_b, result;
  logic [1:0]        data_set;
  logic              cmp_clear, replay_req, busy, done, fault;
  logic [CNT_W-1:0]  retry_cnt;

  int errors = 0;
  int checks = 0;
  int rp;

  dwc_dispatch dut (
    .clk(clk), .reset(reset), .start(start),
    .rep_a_valid(rep_a_valid), .rep_a_data(rep_a_data),
    .rep_b_valid(rep_b_valid), .rep_b_data(rep_b_data),
    .isMatch(isMatch), .interupt_prompt(interupt_prompt), .fault_clr(fault_clr),
    .data_a(data_a), .data_b(data_b), .data_set(data_set),
    .cmp_clear(cmp_clear), .replay_req(replay_req), .busy(busy), .done(done),
    .result(result), .fault(fault), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_a"}, data_a, 0);
    chk({tag, "_data_b"}, data_b, 0);
    chk({tag, "_data_set"}, 32'(data_set), 0);
    chk({tag, "_cmp_clear"}, 32'(cmp_clear), 0);
    chk({tag, "_replay_req"}, 32'(replay_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_retry_cnt"}, 32'(retry_cnt), 0);
  endtask

  task automatic send_both(input logic [31:0] va, input logic [31:0] vb);
    rep_a_valid = 1'b1; rep_a_data = va;
    rep_b_valid = 1'b1; rep_b_data = vb;
    tick();
    rep_a_valid = 1'b0; rep_b_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; rep_a_valid = 0; rep_b_valid = 0; rep_a_data = '0; rep_b_data = '0;
    isMatch = 0; interupt_prompt = 0; fault_clr = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #3;
    chk_all_zero("reset");
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Test 1: simultaneous equal results, match one cycle later
    start = 1; tick(); start = 0;
    chk("t1_clear_pulse", 32'(cmp_clear), 1);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_clear_end", 32'(cmp_clear), 0);
    chk("t1_set_empty", 32'(data_set), 0);
    send_both(32'h5A5A_0001, 32'h5A5A_0001);
    chk("t1_set", 32'(data_set), 3);
    chk("t1_data_a", data_a, 32'h5A5A_0001);
    chk("t1_data_b", data_b, 32'h5A5A_0001);
    isMatch = 1; tick(); isMatch = 0;
    chk("t1_done", 32'(done), 1);
    chk("t1_result", result, 32'h5A5A_0001);
    chk("t1_retry", 32'(retry_cnt), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_result_hold", result, 32'h5A5A_0001);

    // Test 2: staggered strobes, mismatch, matching replay
    start = 1; tick(); start = 0;
    tick();
    rep_a_valid = 1; rep_a_data = 32'hFFFF_FFFF; tick(); rep_a_valid = 0;
    chk("t2_set_a", 32'(data_set), 1);
    chk("t2_data_a", data_a, 32'hFFFF_FFFF);
    tick();
    chk("t2_set_a_hold", 32'(data_set), 1);
    rep_b_valid = 1; rep_b_data = 32'h0; tick(); rep_b_valid = 0;
    chk("t2_set_ab", 32'(data_set), 3);
    chk("t2_data_b", data_b, 0);
    interupt_prompt = 1; tick(); interupt_prompt = 0;
    chk("t2_replay", 32'(replay_req), 1);
    chk("t2_no_done", 32'(done), 0);
    tick();
    chk("t2_reclear", 32'(cmp_clear), 1);
    chk("t2_replay_pulse", 32'(replay_req), 0);
    chk("t2_retry_cnt", 32'(retry_cnt), 1);
    chk("t2_set_cleared", 32'(data_set), 0);
    tick();
    send_both(32'h0000_1234, 32'h0000_1234);
    isMatch = 1; tick(); isMatch = 0;
    chk("t2_done", 32'(done), 1);
    chk("t2_result", result, 32'h0000_1234);
    chk("t2_retry_done", 32'(retry_cnt), 1);
    tick();
    chk("t2_done_pulse", 32'(done), 0);

    // Test 3: persistent mismatch exhausts replays
    rp = 0;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      send_both(32'hAAAA_AAAA, 32'h5555_5555);
      interupt_prompt = 1; tick(); interupt_prompt = 0;
      rp += int'(replay_req);
      tick();
    end
    chk("t3_replays", 32'(rp), 2);
    chk("t3_fault", 32'(fault), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_retry_cnt", 32'(retry_cnt), 2);
    start = 1; tick(); start = 0;
    chk("t3_start_ign_fault", 32'(fault), 1);
    chk("t3_start_ign_busy", 32'(busy), 0);
    chk("t3_start_ign_clr", 32'(cmp_clear), 0);
    fault_clr = 1; tick(); fault_clr = 0;
    chk("t3_clr_fault", 32'(fault), 0);
    chk("t3_clr_retry", 32'(retry_cnt), 0);
    chk("t3_clr_busy", 32'(busy), 0);

    // Test 4: B never arrives, timeout after 16 COLLECT cycles
    start = 1; tick(); start = 0;
    tick();
    rep_a_valid = 1; rep_a_data = 32'h0000_000A; tick(); rep_a_valid = 0;
    chk("t4_set_a", 32'(data_set), 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("t4_set_hold", 32'(data_set), 1);
      chk("t4_no_early_replay", 32'(replay_req), 0);
    end
    tick();
    chk("t4_timeout_replay", 32'(replay_req), 1);
    chk("t4_busy", 32'(busy), 1);
    tick();
    chk("t4_reclear", 32'(cmp_clear), 1);
    chk("t4_retry_cnt", 32'(retry_cnt), 1);
    chk("t4_set_cleared", 32'(data_set), 0);
    tick();
    send_both(32'h0000_00B0, 32'h0000_00B0);
    isMatch = 1; tick(); isMatch = 0;
    chk("t4_done", 32'(done), 1);
    chk("t4_result", result, 32'h0000_00B0);
    tick();

    // Test 5: simultaneous match and mismatch verdicts
    start = 1; tick(); start = 0;
    tick();
    send_both(32'h9, 32'h9);
    isMatch = 1; interupt_prompt = 1; tick(); isMatch = 0; interupt_prompt = 0;
    chk("t5_no_done", 32'(done), 0);
    chk("t5_replay", 32'(replay_req), 1);
    tick();
    chk("t5_retry_cnt", 32'(retry_cnt), 1);
    chk("t5_no_done_later", 32'(done), 0);

    // Test 6: reset while waiting for a verdict
    tick();
    send_both(32'h2, 32'h2);
    chk("t6_wait_a", data_a, 2);
    chk("t6_wait_b", data_b, 2);
    chk("t6_wait_set", 32'(data_set), 3);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("t6_async");
    isMatch = 1; tick(); isMatch = 0;
    chk("t6_no_done", 32'(done), 0);
    reset = 1'b1;
    tick();
    chk("t6_idle", 32'(busy), 0);
    start = 1; tick(); start = 0;
    chk("t6_fresh_clear", 32'(cmp_clear), 1);
    chk("t6_fresh_retry", 32'(retry_cnt), 0);
    chk("t6_fresh_set", 32'(data_set), 0);
    tick();
    send_both(32'h77, 32'h77);
    chk("t6_fresh_loaded", 32'(data_set), 3);
    isMatch = 1; tick(); isMatch = 0;
    chk("t6_fresh_done", 32'(done), 1);
    chk("t6_fresh_result", result, 32'h77);
    tick();
    chk("t6_fresh_pulse", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
